// File: rtl/sudoku_board_reader.sv
// Streams an NxN sudoku board out of the store in row-major order over a valid/ack channel.
// Optional odd parity on the output word is enabled with the SUDOKU_RD_PARITY_EN macro.
module sudoku_board_reader #(
    parameter int N       = 9,
    parameter int DW      = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [3:0]    rd_row,
    output logic [3:0]    rd_col,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          out_par,
    input  logic          out_ack,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [3:0]  LAST_IDX  = 4'(N - 1);
    localparam logic [15:0] TIMER_LIM = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    row_q, row_d;
    logic [3:0]    col_q, col_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [15:0]   timer_q, timer_d;

    // Next-state logic for the walk over the board and the output handshake.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        done_d  = done_q;
        err_d   = err_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    row_d   = 4'd0;
                    col_d   = 4'd0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                data_d  = rd_data;
                valid_d = 1'b1;
                last_d  = (row_q == LAST_IDX) && (col_q == LAST_IDX);
                timer_d = 16'd0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (out_ack) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        done_d  = 1'b1;
                        row_d   = 4'd0;
                        col_d   = 4'd0;
                        state_d = S_IDLE;
                    end else if (col_q == LAST_IDX) begin
                        col_d   = 4'd0;
                        row_d   = row_q + 4'd1;
                        state_d = S_FETCH;
                    end else begin
                        col_d   = col_q + 4'd1;
                        state_d = S_FETCH;
                    end
                end else if ((TIMEOUT != 0) && (timer_q == TIMER_LIM)) begin
                    // consumer stalled too long: drop the word and abort the dump
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= 4'd0;
            col_q   <= 4'd0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            timer_q <= 16'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

`ifdef SUDOKU_RD_PARITY_EN
    function automatic logic odd_parity(input logic [DW-1:0] word);
        return ~^word;
    endfunction

    logic par_q;

    // Parity is captured on the same edge as the data word it covers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (state_q == S_FETCH) begin
            par_q <= odd_parity(rd_data);
        end else begin
            par_q <= par_q;
        end
    end

    assign out_par = par_q;
`else
    assign out_par = 1'b0;
`endif

    assign rd_row    = row_q;
    assign rd_col    = col_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule
